// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package calc_pkg;

  localparam int OPW  = 8;
  localparam int RESW = 16;
  localparam int ITER = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_CLR   = 3'd4
  } state_t;

  // Widen an operand to result width with zero fill.
  function automatic logic [RESW-1:0] zext(input logic [OPW-1:0] v);
    return {{(RESW-OPW){1'b0}}, v};
  endfunction

endpackage

// File: rtl/calc_sequencer_muldiv.sv
// Eight-step sequential engine: shift-add multiply and restoring divide.
// The result output is the value the engine holds after the step in progress,
// so the caller can register it on the same edge that performs the last step.
module seq_muldiv
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            div_mode,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic            step_en,
  output logic            last,
  output logic [RESW-1:0] result
);

  localparam int CNTW = $clog2(ITER);

  logic [CNTW-1:0] cnt;
  logic [RESW-1:0] acc, mcand;
  logic [OPW-1:0]  mplier;
  logic [OPW-1:0]  rem, quot, divisor;

  logic [RESW-1:0] acc_nxt;
  logic [OPW:0]    part;
  logic            ge;
  logic [OPW-1:0]  rem_nxt, quot_nxt;

  // One algorithm step for both engines, evaluated from the current registers.
  always_comb begin
    // NOTE: every output gets a default first so no latch can be inferred.
    acc_nxt  = acc + (mplier[0] ? mcand : '0);
    part     = {rem, quot[OPW-1]};
    ge       = (part >= {1'b0, divisor});
    rem_nxt  = ge ? (part[OPW-1:0] - divisor) : part[OPW-1:0];
    quot_nxt = {quot[OPW-2:0], ge};
    result   = div_mode ? {rem_nxt, quot_nxt} : acc_nxt;
    last     = (cnt == CNTW'(ITER - 1));
  end

  // Load operands on accept, then advance one step per enabled cycle.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the first branch of the clocked block.
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt     <= '0;
      acc     <= '0;
      mcand   <= zext(a);
      mplier  <= b;
      rem     <= '0;
      quot    <= a;
      divisor <= b;
    end else if (step_en) begin
      cnt     <= cnt + CNTW'(1);
      acc     <= acc_nxt;
      mcand   <= {mcand[RESW-2:0], 1'b0};
      mplier  <= {1'b0, mplier[OPW-1:1]};
      rem     <= rem_nxt;
      quot    <= quot_nxt;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Sequencing controller for the calculator result register: captures an
// operation, runs it, and issues exactly one load pulse per result or clear.
module calc_sequencer
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            clear,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [1:0]      op,
  output logic            res_en,
  output logic [RESW-1:0] res_d,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t          state, nxt;
  logic [OPW-1:0]  a_q, b_q;
  op_t             op_q;
  logic            accept, is_md, step_en, last;
  logic [RESW-1:0] md_result, wr_data;

  assign accept  = (state == S_IDLE) && start && !clear;
  assign is_md   = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign step_en = (state == S_EXEC) && is_md && !clear;

  seq_muldiv u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .div_mode (op_q == OP_DIV),
    .a        (a),
    .b        (b),
    .step_en  (step_en),
    .last     (last),
    .result   (md_result)
  );

  // Data written on WRITE: single-cycle add/sub, otherwise the engine output.
  always_comb begin
    wr_data = md_result;
    case (op_q)
      OP_ADD:  wr_data = zext(a_q) + zext(b_q);
      OP_SUB:  wr_data = zext(a_q) - zext(b_q);
      default: wr_data = md_result;
    endcase
  end

  // Next-state decision; clear overrides everything except reset.
  always_comb begin
    nxt = state;
    if (clear) begin
      nxt = S_CLR;
    end else begin
      case (state)
        S_IDLE:  if (start) nxt = S_EXEC;
        S_EXEC:  if (!is_md || last) nxt = S_WRITE;
        S_WRITE: nxt = S_DONE;
        S_DONE:  nxt = S_IDLE;
        S_CLR:   nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // State, operand capture and outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_ADD;
      res_en <= 1'b0;
      res_d  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op_t'(op);
      end
      res_en <= (nxt == S_WRITE) || (nxt == S_CLR);
      busy   <= (nxt == S_EXEC) || (nxt == S_WRITE) || (nxt == S_CLR);
      done   <= (nxt == S_DONE);
      if (nxt == S_CLR)
        res_d <= '0;
      else if (nxt == S_WRITE)
        res_d <= wr_data;
      if (clear || accept)
        err <= 1'b0;
      else if (state == S_EXEC && nxt == S_WRITE && op_q == OP_DIV && b_q == '0)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed cases, aborts, and
// randomized operations against an arithmetic reference model.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, clear;
  logic [7:0]  a_i, b_i;
  logic [1:0]  op_i;
  logic        res_en, busy, done, err;
  logic [15:0] res_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .clear  (clear),
    .a      (a_i),
    .b      (b_i),
    .op     (op_i),
    .res_en (res_en),
    .res_d  (res_d),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {err, result} from plain arithmetic on the operation rules.
  function automatic logic [16:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic        e;
    e = 1'b0;
    case (op)
      2'd0: r = 16'(a) + 16'(b);
      2'd1: r = 16'(a) - 16'(b);
      2'd2: r = 16'(a) * 16'(b);
      default: begin
        if (b == 8'd0) begin
          r = {a, 8'hFF};
          e = 1'b1;
        end else begin
          r = {8'(a % b), 8'(a / b)};
        end
      end
    endcase
    return {e, r};
  endfunction

  // Issue one operation from IDLE and check every cycle up to DONE.
  // Inputs are scrambled while the operation runs to prove capture.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [16:0] m;
    int          lat;
    m   = model(op, a, b);
    lat = op[1] ? 9 : 2;
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    tick();
    start = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      check({tag, " res_en"}, res_en, c == lat);
      check({tag, " busy"},   busy,   c <= lat);
      check({tag, " done"},   done,   c == lat + 1);
      if (c == lat)     check({tag, " res_d"}, res_d, m[15:0]);
      if (c == 1)       check({tag, " err_cleared"}, err, 1'b0);
      if (c == lat + 1) check({tag, " err"}, err, m[16]);
      if (c < lat) begin
        a_i = 8'($urandom); b_i = 8'($urandom); op_i = 2'($urandom);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    a_i = '0; b_i = '0; op_i = '0;
    tick(); tick();
    check("rst res_en", res_en, 1'b0);
    check("rst res_d",  res_d,  16'h0000);
    check("rst busy",   busy,   1'b0);
    check("rst done",   done,   1'b0);
    check("rst err",    err,    1'b0);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic cases.
    run_op(2'd0, 8'd200, 8'd100, "add_200_100");
    run_op(2'd1, 8'd5,   8'd10,  "sub_5_10");
    run_op(2'd1, 8'd10,  8'd5,   "sub_10_5");
    run_op(2'd2, 8'd255, 8'd255, "mul_255_255");
    run_op(2'd2, 8'd0,   8'd37,  "mul_0_37");
    run_op(2'd3, 8'd200, 8'd7,   "div_200_7");
    run_op(2'd3, 8'd100, 8'd0,   "div_100_0");
    check("err sticky idle", err, 1'b1);
    tick();
    check("err sticky idle2", err, 1'b1);
    run_op(2'd0, 8'd1, 8'd2, "add_after_err");

    // Randomized operations.
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), "rand");

    // start held high with ADD: accepted at edges 0, 4, 8.
    start = 1'b1; op_i = 2'd0; a_i = 8'd17; b_i = 8'd34;
    tick();
    for (int c = 1; c <= 12; c++) begin
      check("held res_en", res_en, (c % 4) == 2);
      check("held done",   done,   (c % 4) == 3);
      if ((c % 4) == 2) check("held res_d", res_d, 16'd51);
      if (c == 12) start = 1'b0;
      tick();
    end
    check("held idle busy", busy, 1'b0);

    // clear during cycle 4 of a MUL.
    start = 1'b1; op_i = 2'd2; a_i = 8'd255; b_i = 8'd255;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    clear = 1'b1;
    tick();
    check("clr res_en", res_en, 1'b1);
    check("clr res_d",  res_d,  16'h0000);
    check("clr busy",   busy,   1'b1);
    check("clr done",   done,   1'b0);
    clear = 1'b0;
    tick();
    check("clr idle res_en", res_en, 1'b0);
    check("clr idle busy",   busy,   1'b0);
    for (int c = 0; c < 10; c++) begin
      check("clr no done",   done,   1'b0);
      check("clr no res_en", res_en, 1'b0);
      tick();
    end

    // clear from IDLE also drops a sticky err.
    run_op(2'd3, 8'd100, 8'd0, "div0_then_clear");
    check("err before clear", err, 1'b1);
    clear = 1'b1;
    tick();
    check("idle clr res_en", res_en, 1'b1);
    check("idle clr res_d",  res_d,  16'h0000);
    check("idle clr err",    err,    1'b0);
    clear = 1'b0;
    tick();
    check("idle clr after res_en", res_en, 1'b0);
    check("idle clr after busy",   busy,   1'b0);

    // Reset in cycle 4 of a DIV: no write at all.
    start = 1'b1; op_i = 2'd3; a_i = 8'd9; b_i = 8'd2;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("mid rst res_en", res_en, 1'b0);
    check("mid rst res_d",  res_d,  16'h0000);
    check("mid rst busy",   busy,   1'b0);
    check("mid rst done",   done,   1'b0);
    check("mid rst err",    err,    1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      check("post rst res_en", res_en, 1'b0);
      check("post rst done",   done,   1'b0);
      check("post rst busy",   busy,   1'b0);
      tick();
    end
    run_op(2'd3, 8'd9, 8'd2, "div_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequencing controller for the calculator's 16-bit result register. It accepts an 8-bit operand pair and an opcode and evaluates add, subtract, multiply or divide. Add and subtract take one cycle; multiply and divide run as 8-step sequential algorithms. It then drives the result register's load enable and data for exactly one cycle per completed operation. It sits between the operand/opcode input logic and the result register, which has no reset of its own, so this block also performs the explicit clear write.

## Interface
Parameters:
- none (operand width fixed at 8, result width fixed at 16)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request to run one operation; sampled only in IDLE
- clear  in  1  abort any operation and write 16'h0000 to the result register
- a  in  8  operand A, unsigned
- b  in  8  operand B, unsigned
- op  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV
- res_en  out  1  result-register load enable, one-cycle pulse
- res_d  out  16  result-register data; valid whenever res_en=1
- busy  out  1  high in EXEC, WRITE and CLR
- done  out  1  one-cycle pulse after a completed (non-clear) write
- err  out  1  divide-by-zero flag; sticky until the next accepted start or clear

## Operation
- States: IDLE, EXEC, WRITE, DONE, CLR.
- IDLE, start=1: capture a, b and op into internal registers; clear err; go to EXEC. Input changes after capture have no effect.
- EXEC, ADD/SUB: one cycle, then WRITE.
- EXEC, MUL/DIV: an iteration counter runs 0..7; go to WRITE after the step with count 7.
- WRITE: res_en=1, res_d=result; go to DONE.
- DONE: done=1; go to IDLE.
- clear=1 in any state: go to CLR, discarding any operation in flight. CLR drives res_en=1 and res_d=0, then goes to IDLE. done is not asserted for a clear.
- Priority: rst_n low > clear > start.
- start outside IDLE, including during DONE, is ignored and not queued.
- Arithmetic:
  - ADD: zero-extended a+b; range 0..510.
  - SUB: a−b as 16-bit two's complement, i.e. {8'h00,a} − {8'h00,b}.
  - MUL: unsigned 16-bit shift-add product; no overflow is possible.
  - DIV: restoring division; res_d = {remainder[7:0], quotient[7:0]}.
- Divide by zero (DIV with b=0): quotient=8'hFF, remainder=a, err=1. Still takes the full 8 EXEC cycles.

## Timing
- Reset values (rst_n low at a rising edge):
  - state=IDLE; res_en=0, res_d=0, busy=0, done=0, err=0.
  - Iteration counter and operand registers are cleared to 0.
- Reset mid-operation aborts with no res_en pulse.
- Cycle numbering: start is accepted at edge 0.
  - ADD/SUB: EXEC in cycle 1, WRITE (res_en) in cycle 2, DONE in cycle 3. Result register q updates at the end of cycle 2.
  - MUL/DIV: EXEC in cycles 1–8, WRITE in cycle 9, DONE in cycle 10.
  - Earliest next accepted start is cycle 4 for ADD/SUB and cycle 11 for MUL/DIV.
- clear asserted in cycle k puts CLR in cycle k+1 (res_en=1, res_d=0) and IDLE in cycle k+2.
- All outputs are registered; no combinational path from inputs to outputs.
- res_en is never high for two consecutive cycles, except clear-abort directly following a WRITE (WRITE then CLR).

## Structure
- Package calc_pkg:
  - op_t enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - state_t enum with the five states above.
  - Constants OPW=8, RESW=16, ITER=8.
- Sub-module seq_muldiv holds the sequential multiply/divide engine.
  - Ports: clk, rst_n, load, div_mode, a, b, step_en.
  - Outputs: last (count==7) and result[15:0].
  - Multiply: 16-bit accumulator plus shifting multiplier.
  - Divide: 9-bit partial remainder plus quotient shift register.
- calc_sequencer holds the FSM, operand capture, ADD/SUB logic, output registers and err.

## Test plan
- ADD a=200, b=100, start at edge 0 → res_en only in cycle 2 with res_d=16'h012C; done in cycle 3; busy in cycles 1–2.
- SUB a=5, b=10 → res_d=16'hFFFB in cycle 2. Separately, a=10, b=5 → 16'h0005.
- MUL a=255, b=255 → res_en in cycle 9, res_d=16'hFE01; done in cycle 10. Also 0×37 → 16'h0000.
- DIV a=200, b=7 → res_d=16'h041C, err=0. DIV a=100, b=0 → res_d=16'h64FF, err=1 in cycle 10, and err cleared by the next accepted start.
- Abort cases:
  - clear during cycle 4 of a MUL → CLR in cycle 5 with res_en=1, res_d=0; no done; IDLE in cycle 6.
  - rst_n low in cycle 4 → no res_en at all; all outputs 0.
- start held high continuously with ADD → operations accepted at edges 0, 4, 8; exactly one res_en per operation. Changing a during EXEC does not alter the result.
